// File: rtl/uart_rx_param_if.sv
// Receiver-side signal bundle for uart_rx_param: serial line, enable and frame status.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 rxEn;
    logic                 rx;
    logic                 rxBusy;
    logic                 rxDone;
    logic                 rxErr;
    logic [DATA_BITS-1:0] out;

    modport master (output rxEn, rx, input rxBusy, rxDone, rxErr, out);
    modport slave  (input rxEn, rx, output rxBusy, rxDone, rxErr, out);
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with 3-tap majority sampling and start-glitch rejection.
// Define RX_PARITY_EN to add a parity bit check between the data and stop bits.
module uart_rx_param #(
    parameter int CLOCK_RATE = 12000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            reset,
    uart_rx_param_if.slave  rx_if
);
    localparam int DIV_RAW = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int TW      = (DIV < 2) ? 1 : $clog2(DIV);
    localparam int SW      = $clog2(OVERSAMPLE);
    localparam int BW      = 4;

    localparam logic [TW-1:0] DIV_LAST  = TW'(DIV - 1);
    localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] TAP_A     = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] TAP_B     = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] TAP_C     = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } state_t;

    state_t               state_q, state_d;
    logic                 meta_q, rxs_q;
    logic                 armed_q, armed_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [SW-1:0]        samp_q, samp_d, samp_nxt;
    logic [BW-1:0]        bit_q, bit_d;
    logic                 s0_q, s0_d, s1_q, s1_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] out_q, out_d;
    logic                 done_q, done_d, err_q, err_d;
    logic                 tick, commit, maj;
`ifdef RX_PARITY_EN
    localparam logic PAR_ODD = (PARITY_ODD != 0);
    logic                 par_err_q, par_err_d;
`endif

    assign tick     = (tick_q == DIV_LAST);
    assign samp_nxt = (samp_q == SAMP_LAST) ? '0 : samp_q + 1'b1;
    assign commit   = tick && (samp_nxt == TAP_C);
    assign maj      = (s0_q & s1_q) | (s0_q & rxs_q) | (s1_q & rxs_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q    <= 1'b1;
            rxs_q     <= 1'b1;
            state_q   <= IDLE;
            armed_q   <= 1'b0;
            tick_q    <= '0;
            samp_q    <= '0;
            bit_q     <= '0;
            s0_q      <= 1'b0;
            s1_q      <= 1'b0;
            shift_q   <= '0;
            out_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            meta_q    <= rx_if.rx;
            rxs_q     <= meta_q;
            state_q   <= state_d;
            armed_q   <= armed_d;
            tick_q    <= tick_d;
            samp_q    <= samp_d;
            bit_q     <= bit_d;
            s0_q      <= s0_d;
            s1_q      <= s1_d;
            shift_q   <= shift_d;
            out_q     <= out_d;
            done_q    <= done_d;
            err_q     <= err_d;
`ifdef RX_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    // Tick and sample counters free-run from the start edge, so every bit
    // boundary stays aligned to that edge for the whole frame.
    always_comb begin
        state_d   = state_q;
        armed_d   = 1'b0;
        tick_d    = tick ? '0 : tick_q + 1'b1;
        samp_d    = tick ? samp_nxt : samp_q;
        bit_d     = bit_q;
        s0_d      = (tick && samp_nxt == TAP_A) ? rxs_q : s0_q;
        s1_d      = (tick && samp_nxt == TAP_B) ? rxs_q : s1_q;
        shift_d   = shift_q;
        out_d     = out_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
`ifdef RX_PARITY_EN
        par_err_d = par_err_q;
`endif
        case (state_q)
            IDLE: begin
                tick_d  = '0;
                samp_d  = '0;
                bit_d   = '0;
                armed_d = rxs_q;
`ifdef RX_PARITY_EN
                par_err_d = 1'b0;
`endif
                if (armed_q && !rxs_q) state_d = START;
            end
            START: begin
                if (commit) state_d = maj ? IDLE : DATA;
            end
            DATA: begin
                if (commit) begin
                    shift_d = {maj, shift_q[DATA_BITS-1:1]};
                    if (bit_q == LAST_DATA) begin
                        bit_d = '0;
`ifdef RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef RX_PARITY_EN
            PARITY: begin
                if (commit) begin
                    par_err_d = ((^shift_q) ^ maj) != PAR_ODD;
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (commit) begin
                    if (!maj) begin
                        err_d   = 1'b1;
                        state_d = WAIT_IDLE;
                    end else if (bit_q == LAST_STOP) begin
                        // Leave at the commit tap so an early next start edge is seen.
                        state_d = IDLE;
`ifdef RX_PARITY_EN
                        if (par_err_q) begin
                            err_d = 1'b1;
                        end else begin
                            done_d = 1'b1;
                            out_d  = shift_q;
                        end
`else
                        done_d = 1'b1;
                        out_d  = shift_q;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            WAIT_IDLE: begin
                tick_d = '0;
                samp_d = '0;
                if (rxs_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (!rx_if.rxEn) begin
            state_d = IDLE;
            armed_d = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b0;
            out_d   = out_q;
        end
    end

    assign rx_if.rxBusy = (state_q != IDLE) && (state_q != WAIT_IDLE);
    assign rx_if.rxDone = done_q;
    assign rx_if.rxErr  = err_q;
    assign rx_if.out    = out_q;
endmodule

// File: tb/tb_uart_rx_param.sv
// Randomised self-checking bench for uart_rx_param against a frame-level reference model.
module tb_uart_rx_param;
`ifdef RX_PARITY_EN
    localparam int DB = 7;
`else
    localparam int DB = 8;
`endif
    localparam int CLK_HZ = 9600 * 16 * 8;   // DIV = 8, 128 clocks per bit
    localparam int BIT    = CLK_HZ / 9600;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_rx_param_if #(.DATA_BITS(DB)) rx_if ();

    uart_rx_param #(
        .CLOCK_RATE(CLK_HZ), .BAUD_RATE(9600), .OVERSAMPLE(16),
        .DATA_BITS(DB), .STOP_BITS(1), .PARITY_ODD(0)
    ) dut (
        .clk(clk), .reset(reset), .rx_if(rx_if)
    );

    int n_chk = 0, n_err = 0;
    int cyc = 0, start_cyc = 0, busy_rise_cyc = -100, busy_rises = 0;
    int errs = 0, exp_errs = 0, both = 0, outviol = 0;
    logic rst_last = 1'b1, busy_prev = 1'b0;
    logic [DB-1:0] out_prev = '0;
    logic [8:0] exp_out = '0;
    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_last <= reset;
    end

    always @(negedge clk) begin
        if (rx_if.rxDone) got_q.push_back(9'(rx_if.out));
        if (rx_if.rxErr) errs <= errs + 1;
        if (rx_if.rxDone && rx_if.rxErr) both <= both + 1;
        if (!rst_last && !rx_if.rxDone && rx_if.out !== out_prev) outviol <= outviol + 1;
        if (rx_if.rxBusy && !busy_prev) begin
            busy_rise_cyc <= cyc;
            busy_rises    <= busy_rises + 1;
        end
        busy_prev <= rx_if.rxBusy;
        out_prev  <= rx_if.out;
    end

    // Reference: a frame is accepted iff its stop bit is 1 and its parity holds.
    task automatic model(input logic [8:0] d, input bit stop_ok, input bit par_bad);
        logic [8:0] m;
        bit bad;
        m   = d & 9'((1 << DB) - 1);
        bad = !stop_ok;
`ifdef RX_PARITY_EN
        bad = bad || par_bad;
`endif
        if (bad) exp_errs++;
        else begin
            exp_q.push_back(m);
            exp_out = m;
        end
    endtask

    task automatic score(input string tag);
        chk({tag, "_ndone"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0)
            chk({tag, "_data"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        chk({tag, "_nerr"}, 32'(errs), 32'(exp_errs));
        chk({tag, "_out"}, 32'(rx_if.out), 32'(exp_out));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [8:0] d, input int bitc, input bit stop_ok,
                              input bit par_bad, input int stop_len,
                              input int abort_bit, input bit abort_rst);
        logic [15:0] bits;
        int n;
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < DB; i++) bits[1+i] = d[i];
        n = 1 + DB;
`ifdef RX_PARITY_EN
        bits[n] = (^d[DB-1:0]) ^ par_bad;
        n = n + 1;
`endif
        bits[n] = stop_ok;
        start_cyc = cyc;
        for (int i = 0; i <= n; i++) begin
            rx_if.rx = bits[i];
            if (abort_bit >= 0 && i == 1 + abort_bit) begin
                repeat (bitc / 2) @(negedge clk);
                chk("abort_busy_pre", rx_if.rxBusy, 1);
                if (abort_rst) reset = 1'b1;
                else rx_if.rxEn = 1'b0;
                @(negedge clk);
                chk("abort_busy", rx_if.rxBusy, 0);
                if (abort_rst) begin
                    chk("rst_done", rx_if.rxDone, 0);
                    chk("rst_err", rx_if.rxErr, 0);
                    chk("rst_out", 32'(rx_if.out), 0);
                    exp_out = '0;
                    reset   = 1'b0;
                end
                rx_if.rx = 1'b1;
                repeat (2 * bitc) @(negedge clk);
                rx_if.rxEn = 1'b1;
                return;
            end
            repeat ((i == n) ? stop_len : bitc) @(negedge clk);
        end
        rx_if.rx = 1'b1;
    endtask

    initial begin
        int r0, lat, bc;
        logic [8:0] d;
        bit sok, pb;
        rx_if.rx = 1'b1;
        rx_if.rxEn = 1'b1;
        reset = 1'b1;
        idle(3);
        chk("rst_busy", rx_if.rxBusy, 0);
        chk("rst_done", rx_if.rxDone, 0);
        chk("rst_err", rx_if.rxErr, 0);
        chk("rst_out", 32'(rx_if.out), 0);
        reset = 1'b0;
        idle(20);

        send_frame(9'h0D6, BIT, 1, 0, BIT, -1, 0);
        model(9'h0D6, 1, 0);
        lat = busy_rise_cyc - start_cyc;
        chk("busy_latency_ok", (lat > 0 && lat <= 3), 1);
        idle(2 * BIT);
        score("d6");

        r0 = busy_rises;
        rx_if.rx = 1'b0;
        idle(4 * BIT / 16);
        rx_if.rx = 1'b1;
        idle(BIT - 4 * BIT / 16);
        chk("glitch_busy_low", rx_if.rxBusy, 0);
        chk("glitch_busy_seen", 32'(busy_rises - r0), 1);
        idle(BIT);
        score("glitch");
        send_frame(9'h05A, BIT, 1, 0, BIT, -1, 0);
        model(9'h05A, 1, 0);
        idle(2 * BIT);
        score("after_glitch");

        send_frame(9'h0D6, BIT, 0, 0, BIT, -1, 0);
        model(9'h0D6, 0, 0);
        idle(2 * BIT);
        score("framing");
        send_frame(9'h03C, BIT, 1, 0, BIT, -1, 0);
        model(9'h03C, 1, 0);
        idle(2 * BIT);
        score("after_framing");

        send_frame(9'h0D6, 132, 1, 0, 132, -1, 0);
        model(9'h0D6, 1, 0);
        idle(2 * BIT);
        score("slow3");
        send_frame(9'h0D6, 124, 1, 0, 124, -1, 0);
        model(9'h0D6, 1, 0);
        idle(2 * BIT);
        score("fast3");

        send_frame(9'h081, 132, 1, 0, 66, -1, 0);
        send_frame(9'h07E, 132, 1, 0, 132, -1, 0);
        model(9'h081, 1, 0);
        model(9'h07E, 1, 0);
        idle(2 * BIT);
        score("b2b");

        send_frame(9'h0A5, BIT, 1, 0, BIT, 4, 0);
        idle(BIT);
        score("abort_en");
        send_frame(9'h033, BIT, 1, 0, BIT, 4, 1);
        idle(BIT);
        score("abort_rst");
        send_frame(9'h0A5, BIT, 1, 0, BIT, -1, 0);
        model(9'h0A5, 1, 0);
        idle(2 * BIT);
        score("a5");

`ifdef RX_PARITY_EN
        send_frame(9'h02B, BIT, 1, 0, BIT, -1, 0);
        model(9'h02B, 1, 0);
        idle(2 * BIT);
        score("par_ok");
        send_frame(9'h02B, BIT, 1, 1, BIT, -1, 0);
        model(9'h02B, 1, 1);
        idle(2 * BIT);
        score("par_bad");
`endif

        for (int k = 0; k < 16; k++) begin
            d   = 9'($urandom);
            bc  = $urandom_range(124, 132);
            sok = ($urandom_range(0, 4) != 0);
            pb  = ($urandom_range(0, 3) == 0);
            send_frame(d, bc, sok, pb, bc, -1, 0);
            model(d, sok, pb);
            idle(2 * BIT + $urandom_range(0, 40));
            score("rnd");
        end

        chk("done_err_exclusive", 32'(both), 0);
        chk("out_only_on_done", 32'(outviol), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
